// File: rtl/wave_fetch_ctrl_if.sv
// Display read channel between the fetch scheduler and the PSRAM AXI port:
// read-address handshake plus the returned-beat strobe.
interface wave_fetch_ctrl_if;
    logic [24:0] araddr;
    logic        arvalid;
    logic        arready;
    logic        rvalid;

    modport master (output araddr, output arvalid, input arready, input rvalid);
    modport slave  (input araddr, input arvalid, output arready, output rvalid);
endinterface

// File: rtl/wave_fetch_ctrl.sv
// Per-frame PSRAM read scheduler: one burst per display column each vsync, through a pan/zoom window.
// Optional macro WAVE_FETCH_CLAMP_EN clamps the pending view base to the displayable range.
//
// state   | meaning
// IDLE    | PSRAM not ready, nothing in flight
// WAIT_VS | armed, waiting for a vsync rising edge
// ISSUE   | issuing column bursts, throttled by outstanding count
// DRAIN   | all bursts issued, waiting for the remaining beats
module wave_fetch_ctrl #(
    parameter int NUM_COLS        = 640,
    parameter int BEATS_PER_BURST = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ZOOM_MAX        = 10,
    parameter int PAN_STEP        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              psram_ready,
    input  logic              vsync,
    input  logic              pan_left,
    input  logic              pan_right,
    input  logic              zoom_in,
    input  logic              zoom_out,
    wave_fetch_ctrl_if.master axi_rd,
    output logic              frame_done,
    output logic              busy,
    output logic [7:0]        overrun_cnt,
    output logic [21:0]       view_base,
    output logic [3:0]        view_zoom
);
    localparam int COL_W  = $clog2(NUM_COLS + 1);
    localparam int BEAT_W = (BEATS_PER_BURST > 1) ? $clog2(BEATS_PER_BURST) : 1;
    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(NUM_COLS - 1);
    localparam logic [BEAT_W-1:0] BEAT_LOAD  = BEAT_W'(BEATS_PER_BURST - 1);
    localparam logic [3:0]        OUT_MAX    = 4'(MAX_OUTSTANDING);
    localparam logic [3:0]        ZOOM_LIMIT = 4'(ZOOM_MAX);
`ifdef WAVE_FETCH_CLAMP_EN
    localparam int BW = 24;
    logic [BW-1:0] max_base;
`else
    localparam int BW = 22;
`endif

    typedef enum logic [1:0] {IDLE, WAIT_VS, ISSUE, DRAIN} state_t;

    state_t            state;
    logic              vs_s1, vs_s2, vs_s3;
    logic [COL_W-1:0]  col;
    logic [3:0]        outst;
    logic [BEAT_W-1:0] beats_left;
    logic [21:0]       pend_base;
    logic [3:0]        pend_zoom;

    logic              vs_rise, hs, beat_ok, burst_done;
    logic [3:0]        outst_nx;
    logic [COL_W-1:0]  col_nx;
    logic [21:0]       burst_nx;
    logic              do_pl, do_pr;
    logic [3:0]        zoom_nx;
    logic [BW-1:0]     step_w, base_w;
    logic [21:0]       base_nx;

    always_comb begin
        vs_rise    = vs_s2 & ~vs_s3;
        hs         = axi_rd.arvalid & axi_rd.arready;
        beat_ok    = axi_rd.rvalid & (outst != 4'd0);
        burst_done = beat_ok & (beats_left == '0);
        outst_nx   = outst + {3'd0, hs} - {3'd0, burst_done};
        col_nx     = col + COL_W'(hs);
        burst_nx   = view_base + (22'(col_nx) << view_zoom);
    end

    // Zoom resolves first so a same-cycle pan moves by the new pitch.
    always_comb begin
        do_pl   = pan_left & ~pan_right;
        do_pr   = pan_right & ~pan_left;
        zoom_nx = pend_zoom;
        if (zoom_in && !zoom_out && pend_zoom != 4'd0)
            zoom_nx = pend_zoom - 4'd1;
        else if (zoom_out && !zoom_in && pend_zoom < ZOOM_LIMIT)
            zoom_nx = pend_zoom + 4'd1;
        step_w = BW'(PAN_STEP) << zoom_nx;
        base_w = BW'(pend_base);
`ifdef WAVE_FETCH_CLAMP_EN
        max_base = 24'h40_0000 - (BW'(NUM_COLS - 1) << zoom_nx) - 24'd1;
        if (do_pr)
            base_w = (base_w + step_w > max_base) ? max_base : base_w + step_w;
        else if (do_pl)
            base_w = (step_w > base_w) ? '0 : base_w - step_w;
        if (base_w > max_base)
            base_w = max_base;
`else
        if (do_pr)
            base_w = base_w + step_w;
        else if (do_pl)
            base_w = base_w - step_w;
`endif
        base_nx = base_w[21:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            vs_s1          <= 1'b0;
            vs_s2          <= 1'b0;
            vs_s3          <= 1'b0;
            col            <= '0;
            outst          <= 4'd0;
            beats_left     <= BEAT_LOAD;
            pend_base      <= 22'd0;
            pend_zoom      <= 4'd0;
            view_base      <= 22'd0;
            view_zoom      <= 4'd0;
            axi_rd.araddr  <= 25'd0;
            axi_rd.arvalid <= 1'b0;
            frame_done     <= 1'b0;
            busy           <= 1'b0;
            overrun_cnt    <= 8'd0;
        end else begin
            vs_s1      <= vsync;
            vs_s2      <= vs_s1;
            vs_s3      <= vs_s2;
            pend_zoom  <= zoom_nx;
            pend_base  <= base_nx;
            frame_done <= 1'b0;
            if (vs_rise && (state == ISSUE || state == DRAIN) && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;

            if (!psram_ready) begin
                state          <= IDLE;
                axi_rd.arvalid <= 1'b0;
                busy           <= 1'b0;
                col            <= '0;
                outst          <= 4'd0;
                beats_left     <= BEAT_LOAD;
            end else begin
                col   <= col_nx;
                outst <= outst_nx;
                if (beat_ok)
                    beats_left <= (beats_left == '0) ? BEAT_LOAD : beats_left - BEAT_W'(1);
                case (state)
                    IDLE: state <= WAIT_VS;
                    WAIT_VS: begin
                        if (vs_rise) begin
                            state      <= ISSUE;
                            busy       <= 1'b1;
                            view_base  <= pend_base;
                            view_zoom  <= pend_zoom;
                            col        <= '0;
                            outst      <= 4'd0;
                            beats_left <= BEAT_LOAD;
                        end
                    end
                    ISSUE: begin
                        if (hs && col == LAST_COL) begin
                            state          <= DRAIN;
                            axi_rd.arvalid <= 1'b0;
                        end else begin
                            // Count only falls without a handshake, so a raised arvalid holds.
                            axi_rd.arvalid <= (outst_nx < OUT_MAX);
                            axi_rd.araddr  <= {burst_nx, 3'b000};
                        end
                    end
                    DRAIN: begin
                        if (outst == 4'd0) begin
                            state      <= WAIT_VS;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_wave_fetch_ctrl.sv
// Bench for wave_fetch_ctrl: random AXI slave timing and keypad events against a
// frame-level reference model of the view window, burst addresses and beat accounting.
module tb_wave_fetch_ctrl;
    localparam int NUM_COLS = 640;
    localparam int BEATS    = 4;
    localparam int MAX_OUT  = 2;
    localparam int ZOOM_MAX = 10;
    localparam int PAN_STEP = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic psram_ready = 1'b0;
    logic vsync = 1'b0;
    logic pan_left = 1'b0, pan_right = 1'b0, zoom_in = 1'b0, zoom_out = 1'b0;
    logic        frame_done, busy;
    logic [7:0]  overrun_cnt;
    logic [21:0] view_base;
    logic [3:0]  view_zoom;

    wave_fetch_ctrl_if axi_rd();

    wave_fetch_ctrl #(
        .NUM_COLS(NUM_COLS), .BEATS_PER_BURST(BEATS), .MAX_OUTSTANDING(MAX_OUT),
        .ZOOM_MAX(ZOOM_MAX), .PAN_STEP(PAN_STEP)
    ) dut (
        .clk(clk), .reset(reset), .psram_ready(psram_ready), .vsync(vsync),
        .pan_left(pan_left), .pan_right(pan_right), .zoom_in(zoom_in), .zoom_out(zoom_out),
        .axi_rd(axi_rd), .frame_done(frame_done), .busy(busy), .overrun_cnt(overrun_cnt),
        .view_base(view_base), .view_zoom(view_zoom)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    longint pend_base = 0;
    int     pend_zoom = 0;
    longint exp_vb = 0;
    int     exp_vz = 0;
    int     hs_frame = 0, beats_frame = 0, pending_beats = 0, fd_count = 0;
    bit     quiet = 0, ready_always = 0, rvalid_hold = 0;
    logic        prev_arvalid = 1'b0, prev_arready = 1'b0;
    logic [24:0] prev_araddr = '0, addr_col1 = '0, last_hs_addr = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [24:0] exp_addr(input int column);
        longint idx;
        idx = (exp_vb + (longint'(column) << exp_vz)) & 64'h3F_FFFF;
        return {idx[21:0], 3'b000};
    endfunction

    // One cycle: observe outputs at negedge, then play the AXI slave for the next posedge.
    task automatic step();
        bit rv, ar;
        @(negedge clk);
        if (frame_done) begin
            fd_count++;
            check("fd_cols", hs_frame, NUM_COLS);
            check("fd_beats", pending_beats, 0);
        end
        if (prev_arvalid && !prev_arready && psram_ready && !reset) begin
            check("hold_valid", axi_rd.arvalid, 1);
            check("hold_addr", axi_rd.araddr, prev_araddr);
        end
        if (axi_rd.arvalid)
            check("throttle", 32'(hs_frame - beats_frame / BEATS < MAX_OUT), 1);
        rv = !quiet && !rvalid_hold && pending_beats > 0 &&
             (ready_always || $urandom_range(3, 0) != 0);
        if (rv) begin
            pending_beats--;
            beats_frame++;
        end
        ar = !quiet && (ready_always || $urandom_range(3, 0) != 0);
        if (axi_rd.arvalid && ar) begin
            check("araddr", axi_rd.araddr, exp_addr(hs_frame));
            check("col_range", 32'(hs_frame < NUM_COLS), 1);
            if (hs_frame == 1) addr_col1 = axi_rd.araddr;
            last_hs_addr = axi_rd.araddr;
            hs_frame++;
            pending_beats += BEATS;
        end
        axi_rd.rvalid  = rv;
        axi_rd.arready = ar;
        prev_arvalid = axi_rd.arvalid;
        prev_arready = ar;
        prev_araddr  = axi_rd.araddr;
    endtask

    task automatic key(input bit pl, input bit pr, input bit zi, input bit zo);
        longint stp;
`ifdef WAVE_FETCH_CLAMP_EN
        longint maxb;
`endif
        pan_left = pl; pan_right = pr; zoom_in = zi; zoom_out = zo;
        if (zi && !zo && pend_zoom > 0) pend_zoom--;
        else if (zo && !zi && pend_zoom < ZOOM_MAX) pend_zoom++;
        stp = longint'(PAN_STEP) << pend_zoom;
`ifdef WAVE_FETCH_CLAMP_EN
        maxb = (longint'(1) << 22) - (longint'(NUM_COLS - 1) << pend_zoom) - 1;
        if (pr && !pl) pend_base = (pend_base + stp > maxb) ? maxb : pend_base + stp;
        else if (pl && !pr) pend_base = (stp > pend_base) ? 0 : pend_base - stp;
        if (pend_base > maxb) pend_base = maxb;
`else
        if (pr && !pl) pend_base = (pend_base + stp) & 64'h3F_FFFF;
        else if (pl && !pr) pend_base = (pend_base - stp) & 64'h3F_FFFF;
`endif
        step();
        pan_left = 0; pan_right = 0; zoom_in = 0; zoom_out = 0;
    endtask

    task automatic begin_frame();
        int lat = 0;
        exp_vb = pend_base;
        exp_vz = pend_zoom;
        hs_frame = 0; beats_frame = 0; pending_beats = 0;
        vsync = 1;
        do begin
            step();
            lat++;
        end while (!axi_rd.arvalid && lat < 12);
        vsync = 0;
        check("vs_latency", lat, 4);
        check("view_base", view_base, 32'(exp_vb));
        check("view_zoom", view_zoom, exp_vz);
    endtask

    task automatic wait_done(input int budget);
        int f0 = fd_count;
        int n = 0;
        while (fd_count == f0 && n < budget) begin
            step();
            n++;
        end
        check("frame_done_seen", 32'(fd_count != f0), 1);
        repeat (3) step();
        check("frame_done_once", fd_count - f0, 1);
        check("busy_after", busy, 0);
    endtask

    task automatic reset_checks();
        check("rst_araddr", axi_rd.araddr, 0);
        check("rst_arvalid", axi_rd.arvalid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun_cnt, 0);
        check("rst_view_base", view_base, 0);
        check("rst_view_zoom", view_zoom, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        axi_rd.arready = 1'b0;
        axi_rd.rvalid  = 1'b0;
        repeat (3) step();
        reset_checks();
        reset = 0;
        psram_ready = 1;
        repeat (4) step();
        check("idle_busy", busy, 0);

        // Frame 1: always-ready slave, identity window.
        ready_always = 1;
        begin_frame();
        wait_done(20000);
        check("f1_last_addr", last_hs_addr, 25'h13F8);

        // Frame 2: beats withheld, issue must stall at the outstanding limit.
        rvalid_hold = 1;
        begin_frame();
        repeat (46) step();
        check("holdoff_hs", hs_frame, MAX_OUT);
        check("holdoff_arvalid", axi_rd.arvalid, 0);
        rvalid_hold = 0;
        ready_always = 0;
        wait_done(20000);

        // Frame 3: zoom/pan before vsync, then an overrun vsync during drain.
        repeat (3) key(0, 0, 0, 1);
        repeat (2) key(0, 1, 0, 0);
        check("view_zoom_pending", view_zoom, 0);
        begin_frame();
        check("zoom3", view_zoom, 3);
        check("base256", view_base, 256);
        n = 0;
        while (hs_frame < NUM_COLS && n < 20000) begin
            step();
            n++;
        end
        check("f3_all_issued", hs_frame, NUM_COLS);
        check("col1_addr", addr_col1, 25'h840);
        rvalid_hold = 1;
        step();
        vsync = 1;
        repeat (3) step();
        vsync = 0;
        repeat (5) step();
        check("overrun_cnt", overrun_cnt, 1);
        check("drain_busy", busy, 1);
        rvalid_hold = 0;
        wait_done(20000);
        repeat (20) step();
        check("no_restart", hs_frame, NUM_COLS);
        check("no_restart_busy", busy, 0);

        // Frame 4: psram_ready drop at column 100, then a clean restart.
        begin_frame();
        n = 0;
        while (hs_frame < 100 && n < 5000) begin
            step();
            n++;
        end
        quiet = 1;
        step();
        psram_ready = 0;
        step();
        check("drop_arvalid", axi_rd.arvalid, 0);
        check("drop_busy", busy, 0);
        hs_frame = 0; beats_frame = 0; pending_beats = 0;
        quiet = 0;
        psram_ready = 1;
        repeat (3) step();
        begin_frame();
        wait_done(20000);

        // Random keypad sequences, including simultaneous opposing events.
        for (int f = 0; f < 2; f++) begin
            repeat ($urandom_range(8, 2))
                key($urandom_range(2, 0) == 0, $urandom_range(2, 0) == 0,
                    $urandom_range(2, 0) == 0, $urandom_range(2, 0) == 0);
            begin_frame();
            wait_done(20000);
        end
        check("overrun_final", overrun_cnt, 1);

        // Reset again, then pan left from base 0.
        reset = 1;
        prev_arvalid = 0;
        repeat (2) step();
        reset_checks();
        reset = 0;
        pend_base = 0;
        pend_zoom = 0;
        repeat (3) step();
        key(1, 0, 0, 0);
        begin_frame();
`ifdef WAVE_FETCH_CLAMP_EN
        check("pan_left_from0", view_base, 0);
`else
        check("pan_left_from0", view_base, 22'h3F_FFF0);
`endif
        wait_done(20000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wave_fetch_ctrl.md
# wave_fetch_ctrl

Per-frame PSRAM read scheduler for the waveform display path. It runs in the memory clock domain and owns the display AXI read-address channel. Once per video frame it issues NUM_COLS burst reads into the capture buffer, using a pan/zoom view window driven by keypad events. It throttles outstanding bursts, counts returned beats to detect completion, and flags frames whose fetch could not finish before the next vsync.

## Interface
Parameters:
- NUM_COLS, 640, bursts fetched per frame (one per display column)
- BEATS_PER_BURST, 4, rvalid beats returned per burst
- MAX_OUTSTANDING, 2, bursts in flight limit (1..7)
- ZOOM_MAX, 10, maximum zoom exponent (pitch = 2^zoom bursts per column)
- PAN_STEP, 16, columns moved per pan event

Ports:
- clk  in  1  memory clock; everything here is in this domain
- reset  in  1  asynchronous, active-high reset
- psram_ready  in  1  PSRAM initialised; low forces IDLE
- vsync  in  1  video vsync, asynchronous to clk
- pan_left, pan_right, zoom_in, zoom_out  in  1 each  single-cycle keypad event pulses
- araddr  out  25  burst byte-word address, always {burst_idx[21:0], 3'b000}
- arvalid  out  1  address valid
- arready  in  1  address accepted
- rvalid  in  1  read data beat
- frame_done  out  1  one-cycle pulse when the last beat of a frame returns
- busy  out  1  high in ISSUE or DRAIN
- overrun_cnt  out  8  saturating count of vsync edges missed while busy
- view_base  out  22  active base burst index; view_zoom  out  4  active zoom

## Operation
- Reset values: araddr 0, arvalid 0, frame_done 0, busy 0, overrun_cnt 0, view_base 0, view_zoom 0, pending base/zoom 0, state IDLE.
- vsync passes through a 2-flop synchroniser plus a delay flop. A rising edge is s2 & !s3.
- States:
  - IDLE: psram_ready=1 -> WAIT_VS.
  - WAIT_VS: rising edge -> ISSUE. Pending base/zoom are copied to view_base/view_zoom, and the column counter and outstanding counter are cleared.
  - ISSUE: arvalid = (outstanding < MAX_OUTSTANDING). On handshake (arvalid & arready), column +1. After handshake on column NUM_COLS-1 -> DRAIN.
  - DRAIN: when outstanding == 0 -> WAIT_VS, with frame_done pulsed the same cycle.
- psram_ready=0 in any state -> IDLE next cycle. arvalid drops, all counters clear, and beats still in flight are discarded.
- Address: burst_idx = view_base + (column << view_zoom), mod 2^22. araddr is registered and stable while arvalid is high without arready. arvalid never drops before handshake, except on a psram_ready drop.
- Outstanding counter: +1 on handshake, -1 when the beat counter wraps at BEATS_PER_BURST beats. Handshake and completion in the same cycle leave it unchanged. rvalid beats with outstanding == 0 are ignored.
- A rising vsync edge in ISSUE or DRAIN is ignored for fetch purposes and increments overrun_cnt, which saturates at 255.
- Keypad events update the pending view in any state. They take effect at the next frame start, never mid-frame.
  - pan_left: subtract PAN_STEP << zoom. pan_right: add it.
  - zoom_in: zoom -1, stopping at 0. zoom_out: zoom +1, stopping at ZOOM_MAX.
  - pan_left & pan_right together, or zoom_in & zoom_out together: that pair has no effect.
  - When a pan and a zoom arrive in the same cycle, the zoom applies first and the pan uses the new zoom.

## Timing
- vsync first sampled high at clk edge N -> state ISSUE and arvalid high after edge N+3.
- Handshake at edge K -> the next araddr is valid after edge K, so back-to-back handshakes are possible when arready stays high.
- Throughput is bounded by MAX_OUTSTANDING × BEATS_PER_BURST beat latency. The block adds no bubble beyond the counter update.
- frame_done fires in the cycle after the completing beat is registered.

## Configuration
- WAVE_FETCH_CLAMP_EN defined:
  - Pending base is clamped to 0..max_base, where max_base = 2^22 − ((NUM_COLS−1) << zoom) − 1.
  - A pan past either end saturates at that end.
  - A zoom_out that makes base > max_base clamps base to the new max_base in the same cycle.
- Not defined: base arithmetic and burst_idx wrap modulo 2^22 with no clamping.

## Test plan
- Reset, psram_ready=1, one vsync pulse, arready=1, 4 rvalid beats returned 3 cycles after each handshake -> exactly 640 handshakes with araddr 0x000000, 0x000008 … 0x0013F8, then one frame_done pulse, then busy=0.
- MAX_OUTSTANDING=2 with rvalid held off for 50 cycles -> arvalid low after 2 handshakes until the first burst's 4 beats arrive.
- zoom_out×3 then pan_right×2 before vsync -> view_zoom 3, view_base 256, column 1 address = (256+8)<<3 = 0x000840.
- Second vsync edge while in DRAIN -> overrun_cnt 1, no fetch restart, frame_done still pulses once.
- psram_ready dropped mid-ISSUE at column 100 -> arvalid 0 next cycle, state IDLE; the next frame restarts at column 0.
- pan_left from base 0 -> CLAMP_EN: base stays 0; without it: base 0x3FFFF0.
